csr_mmode_irq: RTL and testbench
================================

// Module: csr_mmode_irq
// PURPOSE
//  Machine-mode CSR file with multi-source interrupt arbitration and trap sequencing for the 3-stage core.
//  Holds mstatus/mie/mip/mtvec/mepc/mcause plus 64-bit mcycle/minstret counters.
//  Prioritises timer, external and NUM_LOCAL_IRQ local interrupts, and supports direct and vectored mtvec.
//  Sits beside the execute stage and redirects fetch via trap_vec on trap entry and mret.
// PARAMETERS
//  NUM_LOCAL_IRQ  4      local irq lines, mapped to mip/mie bits [16+NUM_LOCAL_IRQ-1:16], range 1..16
//  RESET_MTVEC    32'h0  mtvec reset value
//  CNT_EN         1      1: mcycle/minstret implemented; 0: they read 0 and ignore writes
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  csr_addr     in   12  CSR address
//  csr_op       in   2   00 none, 01 write, 10 set (OR), 11 clear (AND~)
//  csr_wdata    in   32  write/set/clear operand
//  csr_rdata    out  32  combinational read of csr_addr (old value)
//  csr_illegal  out  1   comb: csr_op!=00 and csr_addr is unimplemented
//  csr_pc       in   32  PC of the instruction in execute; saved to mepc on a trap
//  csr_is_mret  in   1   mret in execute
//  instr_retire in   1   one instruction retired this cycle
//  timer_irq    in   1   level; MTIP (bit 7)
//  ext_irq      in   1   level; MEIP (bit 11)
//  local_irq    in   NUM_LOCAL_IRQ  levels; mip[16+i]
//  trap_taken   out  1   registered 1-cycle pulse: redirect to trap_vec (trap or mret)
//  trap_vec     out  32  registered redirect target, valid while trap_taken=1
// BEHAVIOUR
//  Reset: all CSRs 0 except mtvec=RESET_MTVEC; counters 0; trap_taken=0; trap_vec=0.
//  Addresses: mstatus 300, mie 304, mtvec 305, mepc 341, mcause 342, mip 344.
//   Counters: mcycle B00, minstret B02, mcycleh B80, minstreth B82.
//   Any other address: csr_rdata=0 and the access has no effect.
//  WARL fields:
//   mstatus: only MIE[3] and MPIE[7] are writable.
//   mie: only bits 7, 11 and [16+N-1:16] are writable.
//   mtvec: bit 1 always 0, so mode 1x reads as 0x.
//   mepc: bits [1:0] always 0.
//  mip: bits are read-only level copies of the irq inputs, registered each cycle (1-cycle latency); writes are ignored.
//  Pending: pend = mip & mie. Trap condition: mstatus.MIE & |pend & !csr_is_mret.
//  Priority: MEI(11) > MTI(7) > local, lowest index first. cause = winning bit number.
//  Trap entry (posedge, when the condition holds):
//   mepc <= csr_pc; mcause <= {1'b1, 31'(cause)}; MPIE <= MIE; MIE <= 0.
//   trap_taken <= 1; trap_vec <= {mtvec[31:2],2'b0} + (mtvec[0] ? cause<<2 : 0).
//  mret: MIE <= MPIE; MPIE <= 1; trap_taken <= 1; trap_vec <= mepc.
//  Otherwise trap_taken <= 0 and trap_vec holds.
//  A trap is never taken in the cycle following a trap, because MIE is then 0.
//  Collisions with a CSR write in the same cycle:
//   trap/mret updates to mstatus, mepc and mcause override the CSR write.
//   CSR writes to other registers still complete.
//   Writing mstatus.MIE=1 takes effect next cycle; it can trap at the earliest one cycle later.
//  Counters: 64-bit. mcycle += 1 every cycle; minstret += instr_retire.
//   A CSR write to either half replaces that half, and the counter does not increment in that cycle.
//   Counters wrap from 2^64-1 to 0.
//  Set/clear ops: new = old | wdata or old & ~wdata, then the WARL mask is applied.
//  Reset mid-trap: any pending redirect is dropped; trap_taken=0 immediately (async).
// TESTING
//  1. Set mtvec=0x100 (direct), mie[7]=1, MIE=1; assert timer_irq with csr_pc=0x40
//     -> trap_taken 1 cycle; trap_vec=0x100; mepc=0x40; mcause=0x80000007; MIE=0; MPIE=1.
//  2. Set mtvec=0x201 (vectored); assert ext_irq and local_irq[2] together
//     -> trap_vec=0x22C (cause 11 wins); mcause=0x8000000B.
//  3. In the handler, issue mret -> trap_taken=1; trap_vec=mepc; MIE=1; MPIE=1.
//     If irq is still asserted, the next trap comes >=1 cycle after the mret pulse.
//  4. Write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF; run 2 cycles
//     -> mcycle reads 0x0, then 0x1; mcycleh=0.
//  5. Write 0xFFFFFFFF to mstatus/mtvec/mip; access address 0x7C0
//     -> mstatus=0x88, mtvec bit1=0, mip unchanged; csr_illegal=1 and rdata=0 at 0x7C0.
//  6. Assert rst while trap_taken=1 -> all outputs 0 immediately; after release, no trap occurs until MIE is set again.

Source files
------------

// File: rtl/csr_mmode_irq_if.sv
// csr_mmode_irq_if: CSR access bus between execute stage and the M-mode CSR file
interface csr_mmode_irq_if;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  modport master (output csr_addr, csr_op, csr_wdata, input csr_rdata, csr_illegal);
  modport slave  (input csr_addr, csr_op, csr_wdata, output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_mmode_irq.sv
// csr_mmode_irq: machine-mode CSR file with interrupt arbitration, trap entry/mret redirect and 64-bit counters
module csr_mmode_irq #(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter logic [31:0] RESET_MTVEC   = 32'h0,
  parameter bit          CNT_EN        = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  csr_mmode_irq_if.slave           bus,
  input  logic [31:0]              csr_pc,
  input  logic                     csr_is_mret,
  input  logic                     instr_retire,
  input  logic                     timer_irq,
  input  logic                     ext_irq,
  input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
  output logic                     trap_taken,
  output logic [31:0]              trap_vec
);
  localparam logic [31:0] LOC_MASK = 32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16);
  localparam logic [31:0] MIE_MASK = LOC_MASK | 32'h0000_0880;
  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mip_q, mip_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic        trap_taken_q, trap_taken_d;
  logic [31:0] trap_vec_q, trap_vec_d;
  logic [31:0] rdata, wval, pend;
  logic        legal, we, trap;
  logic [4:0]  cause;
  // Combinational read of the addressed CSR (pre-update value) and address decode
  always_comb begin
    rdata = 32'h0;
    legal = 1'b1;
    case (bus.csr_addr)
      12'h300: rdata = mstatus_q;
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h344: rdata = mip_q;
      12'hB00: rdata = mcycle_q[31:0];
      12'hB80: rdata = mcycle_q[63:32];
      12'hB02: rdata = minstret_q[31:0];
      12'hB82: rdata = minstret_q[63:32];
      default: legal = 1'b0;
    endcase
  end
  assign bus.csr_rdata   = rdata;
  assign bus.csr_illegal = (bus.csr_op != 2'b00) && !legal;
  assign we   = (bus.csr_op != 2'b00) && legal;
  assign wval = bus.csr_op == 2'b01 ? bus.csr_wdata :
                bus.csr_op == 2'b10 ? rdata | bus.csr_wdata : rdata & ~bus.csr_wdata;
  assign pend = mip_q & mie_q;
  assign trap = mstatus_q[3] && |pend && !csr_is_mret;
  // Interrupt priority: MEI over MTI over local lines, lowest local index wins
  always_comb begin
    cause = 5'd0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--)
      if (pend[16+i]) cause = 5'(16 + i);
    if (pend[7]) cause = 5'd7;
    if (pend[11]) cause = 5'd11;
  end
  // Next state: CSR writes first, then trap/mret overrides mstatus/mepc/mcause; counters tick unless written
  always_comb begin
    mip_d = 32'h0;
    mip_d[7] = timer_irq;
    mip_d[11] = ext_irq;
    mip_d[16 +: NUM_LOCAL_IRQ] = local_irq;
    mstatus_d = (we && bus.csr_addr == 12'h300) ? wval & 32'h88 : mstatus_q;
    mie_d = (we && bus.csr_addr == 12'h304) ? wval & MIE_MASK : mie_q;
    mtvec_d = (we && bus.csr_addr == 12'h305) ? wval & ~32'h2 : mtvec_q;
    mepc_d = (we && bus.csr_addr == 12'h341) ? wval & ~32'h3 : mepc_q;
    mcause_d = (we && bus.csr_addr == 12'h342) ? wval : mcause_q;
    trap_taken_d = 1'b0;
    trap_vec_d = trap_vec_q;
    mcycle_d = CNT_EN ? mcycle_q + 64'd1 : 64'd0;
    minstret_d = CNT_EN ? minstret_q + 64'(instr_retire) : 64'd0;
    if (CNT_EN && we) begin
      mcycle_d = bus.csr_addr == 12'hB00 ? {mcycle_q[63:32], wval} :
                 bus.csr_addr == 12'hB80 ? {wval, mcycle_q[31:0]} : mcycle_d;
      minstret_d = bus.csr_addr == 12'hB02 ? {minstret_q[63:32], wval} :
                   bus.csr_addr == 12'hB82 ? {wval, minstret_q[31:0]} : minstret_d;
    end
    if (trap) begin
      mepc_d = csr_pc & ~32'h3;
      mcause_d = {1'b1, 26'b0, cause};
      mstatus_d = {24'b0, mstatus_q[3], 7'b0};
      trap_taken_d = 1'b1;
      trap_vec_d = {mtvec_q[31:2], 2'b0} + (mtvec_q[0] ? {25'b0, cause, 2'b0} : 32'h0);
    end else if (csr_is_mret) begin
      mstatus_d = {24'b0, 1'b1, 3'b0, mstatus_q[7], 3'b0};
      trap_taken_d = 1'b1;
      trap_vec_d = mepc_q;
    end
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q <= 32'h0;
      mie_q <= 32'h0;
      mtvec_q <= RESET_MTVEC & ~32'h2;
      mepc_q <= 32'h0;
      mcause_q <= 32'h0;
      mip_q <= 32'h0;
      mcycle_q <= 64'h0;
      minstret_q <= 64'h0;
      trap_taken_q <= 1'b0;
      trap_vec_q <= 32'h0;
    end else begin
      mstatus_q <= mstatus_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mip_q <= mip_d;
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
      trap_taken_q <= trap_taken_d;
      trap_vec_q <= trap_vec_d;
    end
  end
  assign trap_taken = trap_taken_q;
  assign trap_vec   = trap_vec_q;
endmodule

// File: tb/tb_csr_mmode_irq.sv
// tb_csr_mmode_irq: directed table plus trap/mret/counter/reset sequences for csr_mmode_irq
module tb_csr_mmode_irq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] csr_pc = 32'h0;
  logic        csr_is_mret = 1'b0, instr_retire = 1'b0, timer_irq = 1'b0, ext_irq = 1'b0;
  logic [3:0]  local_irq = 4'h0;
  logic        trap_taken;
  logic [31:0] trap_vec;
  int          n_cmp = 0, n_bad = 0;
  csr_mmode_irq_if bus ();
  csr_mmode_irq #(.NUM_LOCAL_IRQ(4), .RESET_MTVEC(32'h0), .CNT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .csr_pc(csr_pc), .csr_is_mret(csr_is_mret),
    .instr_retire(instr_retire), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .local_irq(local_irq), .trap_taken(trap_taken), .trap_vec(trap_vec)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    bus.csr_addr = a;
    bus.csr_op = op;
    bus.csr_wdata = d;
    tick();
    bus.csr_op = 2'b00;
  endtask
  task automatic chk_csr(input string nm, input logic [11:0] a, input logic [31:0] e);
    bus.csr_addr = a;
    bus.csr_op = 2'b00;
    #1;
    chk(nm, bus.csr_rdata, e);
  endtask
  task automatic wait_trap(input int max, output int n);
    n = 0;
    while (!trap_taken && n < max) begin
      tick();
      n++;
    end
  endtask
  initial begin
    int n, seen;
    tbl[0]  = '{12'h300, 2'b01, 32'hFFFF_FFFF, 32'h0000_0088};
    tbl[1]  = '{12'h300, 2'b11, 32'h0000_0008, 32'h0000_0080};
    tbl[2]  = '{12'h300, 2'b10, 32'h0000_0001, 32'h0000_0080};
    tbl[3]  = '{12'h304, 2'b01, 32'hFFFF_FFFF, 32'h000F_0880};
    tbl[4]  = '{12'h304, 2'b11, 32'h0000_0080, 32'h000F_0800};
    tbl[5]  = '{12'h305, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[6]  = '{12'h305, 2'b01, 32'h0000_0103, 32'h0000_0101};
    tbl[7]  = '{12'h341, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    tbl[8]  = '{12'h342, 2'b01, 32'h1234_5678, 32'h1234_5678};
    tbl[9]  = '{12'h344, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[10] = '{12'h7C0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[11] = '{12'h300, 2'b01, 32'h0000_0000, 32'h0000_0000};
    tbl[12] = '{12'h304, 2'b01, 32'h0000_0000, 32'h0000_0000};
    bus.csr_addr = 12'h0;
    bus.csr_op = 2'b00;
    bus.csr_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("rst_trap_taken", {31'b0, trap_taken}, 32'h0);
    chk("rst_trap_vec", trap_vec, 32'h0);
    chk_csr("rst_mstatus", 12'h300, 32'h0);
    chk_csr("rst_mtvec", 12'h305, 32'h0);
    chk_csr("rst_mcause", 12'h342, 32'h0);
    tick();
    bus.csr_addr = 12'h7C0; bus.csr_op = 2'b01; bus.csr_wdata = 32'hFFFF_FFFF;
    #1 chk("illegal_7c0", {31'b0, bus.csr_illegal}, 32'h1);
    chk("rdata_7c0", bus.csr_rdata, 32'h0);
    bus.csr_addr = 12'h300;
    #1 chk("illegal_300", {31'b0, bus.csr_illegal}, 32'h0);
    bus.csr_addr = 12'h7C0; bus.csr_op = 2'b00;
    #1 chk("illegal_noop", {31'b0, bus.csr_illegal}, 32'h0);
    for (int i = 0; i < 13; i++) begin
      wr(tbl[i].addr, tbl[i].op, tbl[i].wdata);
      chk($sformatf("vec%0d_%h", i, tbl[i].addr), bus.csr_rdata, tbl[i].exp);
    end
    // timer trap, direct mode
    wr(12'h305, 2'b01, 32'h100);
    wr(12'h304, 2'b01, 32'h80);
    wr(12'h300, 2'b01, 32'h8);
    timer_irq = 1'b1;
    csr_pc = 32'h40;
    wait_trap(5, n);
    chk("t1_latency", 32'(n), 32'd2);
    chk("t1_vec", trap_vec, 32'h100);
    chk_csr("t1_mepc", 12'h341, 32'h40);
    chk_csr("t1_mcause", 12'h342, 32'h8000_0007);
    chk_csr("t1_mstatus", 12'h300, 32'h80);
    timer_irq = 1'b0;
    tick();
    chk("t1_pulse_end", {31'b0, trap_taken}, 32'h0);
    // vectored, external beats local
    wr(12'h305, 2'b01, 32'h201);
    wr(12'h304, 2'b01, 32'h0004_0800);
    wr(12'h300, 2'b01, 32'h8);
    csr_pc = 32'h80;
    ext_irq = 1'b1;
    local_irq = 4'b0100;
    wait_trap(5, n);
    chk("t2_latency", 32'(n), 32'd2);
    chk("t2_vec", trap_vec, 32'h22C);
    chk_csr("t2_mcause", 12'h342, 32'h8000_000B);
    chk_csr("t2_mepc", 12'h341, 32'h80);
    // mret with irq still pending
    csr_is_mret = 1'b1;
    tick();
    csr_is_mret = 1'b0;
    chk("t3_mret_pulse", {31'b0, trap_taken}, 32'h1);
    chk("t3_mret_vec", trap_vec, 32'h80);
    chk_csr("t3_mstatus", 12'h300, 32'h88);
    tick();
    chk("t3_retrap", {31'b0, trap_taken}, 32'h1);
    chk("t3_retrap_vec", trap_vec, 32'h22C);
    tick();
    chk("t3_no_b2b", {31'b0, trap_taken}, 32'h0);
    // trap colliding with CSR writes
    csr_pc = 32'h90;
    local_irq = 4'b0000;
    wr(12'h300, 2'b01, 32'h8);
    wr(12'h305, 2'b01, 32'h300);
    chk("col_taken", {31'b0, trap_taken}, 32'h1);
    chk("col_vec_old_mtvec", trap_vec, 32'h22C);
    chk_csr("col_mtvec", 12'h305, 32'h300);
    bus.csr_addr = 12'h341; bus.csr_op = 2'b01; bus.csr_wdata = 32'h1234;
    #1 chk("col_mepc_rd", bus.csr_rdata, 32'h90);
    bus.csr_op = 2'b00;
    ext_irq = 1'b0;
    tick();
    // counters
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
    tick();
    chk_csr("mcycle_wrap", 12'hB00, 32'h0);
    chk_csr("mcycleh_wrap", 12'hB80, 32'h0);
    tick();
    chk_csr("mcycle_inc", 12'hB00, 32'h1);
    instr_retire = 1'b1;
    wr(12'hB02, 2'b01, 32'h5);
    chk_csr("minstret_wr", 12'hB02, 32'h5);
    tick();
    chk_csr("minstret_inc", 12'hB02, 32'h6);
    instr_retire = 1'b0;
    tick();
    chk_csr("minstret_hold", 12'hB02, 32'h6);
    chk_csr("minstreth", 12'hB82, 32'h0);
    // reset during a trap pulse
    wr(12'h305, 2'b01, 32'h100);
    wr(12'h304, 2'b01, 32'h80);
    wr(12'h300, 2'b01, 32'h8);
    timer_irq = 1'b1;
    wait_trap(5, n);
    chk("t6_pre_taken", {31'b0, trap_taken}, 32'h1);
    #2 rst = 1'b1;
    #1 chk("t6_async_taken", {31'b0, trap_taken}, 32'h0);
    chk("t6_async_vec", trap_vec, 32'h0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (trap_taken) seen++;
    end
    chk("t6_no_trap", 32'(seen), 32'd0);
    wr(12'h304, 2'b01, 32'h80);
    wr(12'h300, 2'b01, 32'h8);
    wait_trap(5, n);
    chk("t6_retrap_latency", 32'(n), 32'd1);
    chk("t6_retrap_vec", trap_vec, 32'h0);
    timer_irq = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
